// File: rtl/alu_pkg.sv
// Shared opcode encodings, tag constants and the reservation-entry record
// used by the ALU reservation station and its execute datapath.
package alu_pkg;

    // Entry fields are sized for the widest supported configuration
    // (DATA_W <= 64, TAG_W <= 8, OP_W <= 8); narrower builds zero-extend into them.
    localparam int unsigned ALU_DATA_MAX = 64;
    localparam int unsigned ALU_TAG_MAX  = 8;
    localparam int unsigned ALU_OP_MAX   = 8;

    localparam logic [ALU_OP_MAX-1:0] OP_NOP  = 8'd0;
    localparam logic [ALU_OP_MAX-1:0] OP_ADD  = 8'd1;
    localparam logic [ALU_OP_MAX-1:0] OP_SUB  = 8'd2;
    localparam logic [ALU_OP_MAX-1:0] OP_SLL  = 8'd3;
    localparam logic [ALU_OP_MAX-1:0] OP_SLT  = 8'd4;
    localparam logic [ALU_OP_MAX-1:0] OP_SLTU = 8'd5;
    localparam logic [ALU_OP_MAX-1:0] OP_XOR  = 8'd6;
    localparam logic [ALU_OP_MAX-1:0] OP_SRL  = 8'd7;
    localparam logic [ALU_OP_MAX-1:0] OP_SRA  = 8'd8;
    localparam logic [ALU_OP_MAX-1:0] OP_OR   = 8'd9;
    localparam logic [ALU_OP_MAX-1:0] OP_AND  = 8'd10;

    localparam logic [ALU_TAG_MAX-1:0] TAG_FREE = '0;

    typedef struct packed {
        logic                    valid;
        logic [ALU_OP_MAX-1:0]   op;
        logic [ALU_TAG_MAX-1:0]  dest;
        logic [ALU_TAG_MAX-1:0]  tag1;
        logic [ALU_DATA_MAX-1:0] data1;
        logic [ALU_TAG_MAX-1:0]  tag2;
        logic [ALU_DATA_MAX-1:0] data2;
    } rs_entry_t;

    // A waiting operand is woken only by a broadcast of its own, nonzero tag.
    function automatic logic tag_hit(input logic [ALU_TAG_MAX-1:0] t,
                                     input logic [ALU_TAG_MAX-1:0] c);
        return (t != TAG_FREE) && (t == c);
    endfunction

endpackage

// File: rtl/alu_station_if.sv
// Dispatch / result-broadcast / output handshake bundle of the ALU station.
// master = dispatcher and CDB side, slave = the station.
interface alu_station_if #(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned OP_W     = 4
);
    localparam int unsigned FC_W = $clog2(RS_DEPTH + 1);

    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_dest;
    logic [TAG_W-1:0]  disp_tag1;
    logic [TAG_W-1:0]  disp_tag2;
    logic [DATA_W-1:0] disp_data1;
    logic [DATA_W-1:0] disp_data2;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;

    logic [FC_W-1:0]   free_count;

    modport master (
        output disp_valid, disp_op, disp_dest, disp_tag1, disp_tag2, disp_data1, disp_data2,
        output cdb_valid, cdb_tag, cdb_data, out_ready,
        input  disp_ready, out_valid, out_tag, out_data, free_count
    );

    modport slave (
        input  disp_valid, disp_op, disp_dest, disp_tag1, disp_tag2, disp_data1, disp_data2,
        input  cdb_valid, cdb_tag, cdb_data, out_ready,
        output disp_ready, out_valid, out_tag, out_data, free_count
    );
endinterface

// File: rtl/alu_exec.sv
// Combinational integer ALU: result_c = op(a, b), modulo 2^DATA_W.
// Shifts use the low $clog2(DATA_W) bits of b; unknown opcodes yield zero.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result_c
);
    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]       shamt;
    logic [ALU_OP_MAX-1:0] op_x;

    assign shamt = b[SH_W-1:0];
    assign op_x  = ALU_OP_MAX'(op);

    always_comb begin
        result_c = '0;
        case (op_x)
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_SLL:  result_c = a << shamt;
            OP_SLT:  result_c = DATA_W'($signed(a) < $signed(b));
            OP_SLTU: result_c = DATA_W'(a < b);
            OP_XOR:  result_c = a ^ b;
            OP_SRL:  result_c = a >> shamt;
            OP_SRA:  result_c = $unsigned($signed(a) >>> shamt);
            OP_OR:   result_c = a | b;
            OP_AND:  result_c = a & b;
            default: result_c = '0;
        endcase
    end
endmodule

// File: rtl/alu_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive on
// the CDB, then issues one per cycle through alu_exec into a registered output.
// Define ALU_STATION_AGE_EN for oldest-first issue (age matrix); otherwise lowest index wins.
module alu_station
    import alu_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned OP_W     = 4
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    alu_station_if.slave io
);
    localparam int unsigned IDX_W = $clog2(RS_DEPTH);
    localparam int unsigned FC_W  = $clog2(RS_DEPTH + 1);

    rs_entry_t         ent_q [RS_DEPTH];
    rs_entry_t         ent_d [RS_DEPTH];
    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [FC_W-1:0]   free_q,      free_d;
    logic              disp_ready_q, disp_ready_d;

    logic [RS_DEPTH-1:0]    ready_vec;
    logic [RS_DEPTH-1:0]    sel_vec;
    logic [IDX_W-1:0]       issue_idx;
    logic [IDX_W-1:0]       disp_idx;
    logic                   issue_go;
    logic                   disp_fire;
    logic                   cdb_on;
    logic [ALU_TAG_MAX-1:0] cdb_tag_x;
    rs_entry_t              new_ent;
    logic [OP_W-1:0]        exec_op;
    logic [DATA_W-1:0]      exec_a, exec_b, exec_res;

    assign cdb_on    = io.cdb_valid;
    assign cdb_tag_x = ALU_TAG_MAX'(io.cdb_tag);
    assign disp_fire = io.disp_valid && disp_ready_q;

    // Readiness and slot choice look only at registered state.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_vec[i] = ent_q[i].valid && (ent_q[i].tag1 == TAG_FREE)
                           && (ent_q[i].tag2 == TAG_FREE);
        end
    end

    always_comb begin
        disp_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) disp_idx = IDX_W'(i);
        end
    end

`ifdef ALU_STATION_AGE_EN
    // older_q[j][i] set means entry j was dispatched before entry i.
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] older_d [RS_DEPTH];

    always_comb begin
        sel_vec = ready_vec;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (ready_vec[j] && older_q[j][i]) sel_vec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        older_d = older_q;
        if (disp_fire) begin
            older_d[disp_idx] = '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (IDX_W'(j) != disp_idx) older_d[j][disp_idx] = 1'b1;
            end
        end
        if (flush) begin
            for (int j = 0; j < RS_DEPTH; j++) older_d[j] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < RS_DEPTH; j++) older_q[j] <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`else
    assign sel_vec = ready_vec;
`endif

    always_comb begin
        issue_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (sel_vec[i]) issue_idx = IDX_W'(i);
        end
    end

    assign issue_go = (|ready_vec) && (!out_valid_q || io.out_ready);
    assign exec_op  = OP_W'(ent_q[issue_idx].op);
    assign exec_a   = DATA_W'(ent_q[issue_idx].data1);
    assign exec_b   = DATA_W'(ent_q[issue_idx].data2);

    alu_exec #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_exec (
        .op       (exec_op),
        .a        (exec_a),
        .b        (exec_b),
        .result_c (exec_res)
    );

    // Incoming entry snoops the CDB so a same-cycle broadcast is not lost.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.op    = ALU_OP_MAX'(io.disp_op);
        new_ent.dest  = ALU_TAG_MAX'(io.disp_dest);
        new_ent.tag1  = ALU_TAG_MAX'(io.disp_tag1);
        new_ent.data1 = ALU_DATA_MAX'(io.disp_data1);
        new_ent.tag2  = ALU_TAG_MAX'(io.disp_tag2);
        new_ent.data2 = ALU_DATA_MAX'(io.disp_data2);
        if (cdb_on && tag_hit(new_ent.tag1, cdb_tag_x)) begin
            new_ent.tag1  = TAG_FREE;
            new_ent.data1 = ALU_DATA_MAX'(io.cdb_data);
        end
        if (cdb_on && tag_hit(new_ent.tag2, cdb_tag_x)) begin
            new_ent.tag2  = TAG_FREE;
            new_ent.data2 = ALU_DATA_MAX'(io.cdb_data);
        end
    end

    // Next state: wakeup, issue, dispatch, then flush overriding all of them.
    always_comb begin
        ent_d       = ent_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        free_d      = '0;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].valid && cdb_on && tag_hit(ent_q[i].tag1, cdb_tag_x)) begin
                ent_d[i].tag1  = TAG_FREE;
                ent_d[i].data1 = ALU_DATA_MAX'(io.cdb_data);
            end
            if (ent_q[i].valid && cdb_on && tag_hit(ent_q[i].tag2, cdb_tag_x)) begin
                ent_d[i].tag2  = TAG_FREE;
                ent_d[i].data2 = ALU_DATA_MAX'(io.cdb_data);
            end
        end

        if (issue_go) begin
            ent_d[issue_idx].valid = 1'b0;
            out_valid_d            = 1'b1;
            out_tag_d              = TAG_W'(ent_q[issue_idx].dest);
            out_data_d             = exec_res;
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (disp_fire) ent_d[disp_idx] = new_ent;

        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_d[i].valid = 1'b0;
            out_valid_d = 1'b0;
        end

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!ent_d[i].valid) free_d = free_d + FC_W'(1);
        end
        disp_ready_d = (free_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_data_q   <= '0;
            free_q       <= FC_W'(RS_DEPTH);
            disp_ready_q <= 1'b1;
        end else begin
            ent_q        <= ent_d;
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_data_q   <= out_data_d;
            free_q       <= free_d;
            disp_ready_q <= disp_ready_d;
        end
    end

    assign io.disp_ready = disp_ready_q;
    assign io.out_valid  = out_valid_q;
    assign io.out_tag    = out_tag_q;
    assign io.out_data   = out_data_q;
    assign io.free_count = free_q;

endmodule

// File: tb/tb_alu_station.sv
// Self-checking bench for alu_station: opcode table through a result scoreboard,
// plus wakeup, ordering, full-station, flush and reset sequences.
module tb_alu_station;
    import alu_pkg::*;

    localparam int unsigned RS_DEPTH = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned OP_W     = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_station_if #(.RS_DEPTH(RS_DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) io ();

    alu_station #(.RS_DEPTH(RS_DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (io)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io.disp_valid = 1'b0;
        io.disp_op    = '0;
        io.disp_dest  = '0;
        io.disp_tag1  = '0;
        io.disp_tag2  = '0;
        io.disp_data1 = '0;
        io.disp_data2 = '0;
        io.cdb_valid  = 1'b0;
        io.cdb_tag    = '0;
        io.cdb_data   = '0;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] t1,
                            input logic [31:0] d1, input logic [3:0] t2, input logic [31:0] d2);
        io.disp_valid = 1'b1;
        io.disp_op    = op;
        io.disp_dest  = dest;
        io.disp_tag1  = t1;
        io.disp_data1 = d1;
        io.disp_tag2  = t2;
        io.disp_data2 = d2;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] t1,
                            input logic [31:0] d1, input logic [3:0] t2, input logic [31:0] d2);
        int guard = 0;
        while (!io.disp_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!io.disp_ready) check("disp_ready_timeout", 32'(io.disp_ready), 32'd1);
        set_disp(op, dest, t1, d1, t2, d2);
        tick();
        io.disp_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] data);
        io.cdb_valid = 1'b1;
        io.cdb_tag   = tag;
        io.cdb_data  = data;
        tick();
        io.cdb_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [31:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    // Output monitor: scoreboard pop on each accepted result, hold check while stalled.
    logic        hold_pend = 1'b0;
    logic [3:0]  hold_tag;
    logic [31:0] hold_data;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && io.out_valid) begin
                check("hold_tag", 32'(io.out_tag), 32'(hold_tag));
                check("hold_data", io.out_data, hold_data);
            end
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(io.out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_tag", 32'(io.out_tag), 32'(mon_e.tag));
                    check("out_data", io.out_data, mon_e.data);
                end
                hold_pend = 1'b0;
            end else if (io.out_valid) begin
                hold_pend = 1'b1;
                hold_tag  = io.out_tag;
                hold_data = io.out_data;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs [19];

    task automatic fill_waiting(input logic [3:0] wait_tag);
        for (int i = 0; i < RS_DEPTH; i++) begin
            dispatch(4'(OP_ADD), 4'(i + 1), wait_tag, 32'd0, 4'd0, 32'(i));
        end
    endtask

    initial begin
        vecs[0]  = '{4'(OP_ADD),  32'd5,          32'd7,          32'd12};
        vecs[1]  = '{4'(OP_ADD),  32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
        vecs[2]  = '{4'(OP_SUB),  32'd20,         32'd8,          32'd12};
        vecs[3]  = '{4'(OP_SUB),  32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[4]  = '{4'(OP_SLL),  32'd1,          32'd31,         32'h8000_0000};
        vecs[5]  = '{4'(OP_SLL),  32'd1,          32'd33,         32'h0000_0002};
        vecs[6]  = '{4'(OP_SLT),  32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[7]  = '{4'(OP_SLT),  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{4'(OP_SLT),  32'h8000_0000,  32'h7FFF_FFFF,  32'd1};
        vecs[9]  = '{4'(OP_SLTU), 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[10] = '{4'(OP_SLTU), 32'd1,          32'hFFFF_FFFF,  32'd1};
        vecs[11] = '{4'(OP_XOR),  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
        vecs[12] = '{4'(OP_SRL),  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[13] = '{4'(OP_SRA),  32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[14] = '{4'(OP_SRA),  32'h8000_0000,  32'd63,         32'hFFFF_FFFF};
        vecs[15] = '{4'(OP_OR),   32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
        vecs[16] = '{4'(OP_AND),  32'hFFFF_00FF,  32'h0F0F_0F0F,  32'h0F0F_000F};
        vecs[17] = '{4'(OP_NOP),  32'd5,          32'd5,          32'd0};
        vecs[18] = '{4'd15,       32'd9,          32'd3,          32'd0};

        idle_inputs();
        io.out_ready = 1'b1;
        flush        = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid",  32'(io.out_valid),  32'd0);
        check("rst_out_tag",    32'(io.out_tag),    32'd0);
        check("rst_out_data",   io.out_data,        32'd0);
        check("rst_free_count", 32'(io.free_count), 32'(RS_DEPTH));
        check("rst_disp_ready", 32'(io.disp_ready), 32'd1);

        // Ready-at-dispatch latency: transfer edge, then the result edge.
        push_exp(4'd9, 32'd12);
        set_disp(4'(OP_ADD), 4'd9, 4'd0, 32'd5, 4'd0, 32'd7);
        tick();
        io.disp_valid = 1'b0;
        check("lat_after_dispatch_edge", 32'(io.out_valid), 32'd0);
        tick();
        check("lat_after_second_edge", 32'(io.out_valid), 32'd1);
        check("lat_out_tag", 32'(io.out_tag), 32'd9);
        check("lat_out_data", io.out_data, 32'd12);
        drain("latency");

        for (int i = 0; i < 19; i++) begin
            push_exp(4'((i % 15) + 1), vecs[i].exp);
            dispatch(vecs[i].op, 4'((i % 15) + 1), 4'd0, vecs[i].a, 4'd0, vecs[i].b);
        end
        drain("optable");

        // Wakeup after dispatch.
        dispatch(4'(OP_SUB), 4'd6, 4'd3, 32'd0, 4'd0, 32'd8);
        tick();
        tick();
        check("wake_waiting_valid", 32'(io.out_valid), 32'd0);
        check("wake_waiting_free", 32'(io.free_count), 32'(RS_DEPTH - 1));
        push_exp(4'd6, 32'd12);
        broadcast(4'd3, 32'd20);
        drain("wake_late");

        // Dispatch and matching broadcast in the same cycle.
        push_exp(4'd7, 32'd12);
        set_disp(4'(OP_SUB), 4'd7, 4'd3, 32'hDEAD_BEEF, 4'd0, 32'd8);
        io.cdb_valid = 1'b1;
        io.cdb_tag   = 4'd3;
        io.cdb_data  = 32'd20;
        tick();
        idle_inputs();
        drain("wake_same_cycle");

        // Second-operand wakeup.
        dispatch(4'(OP_SUB), 4'd8, 4'd0, 32'd50, 4'd4, 32'd0);
        push_exp(4'd8, 32'd42);
        broadcast(4'd4, 32'd8);
        drain("wake_op2");

        // Slot 0 reused after slot 1 was filled: oldest vs lowest-index ordering.
        dispatch(4'(OP_ADD), 4'd1, 4'd6, 32'd0, 4'd0, 32'd1);
        dispatch(4'(OP_ADD), 4'd2, 4'd7, 32'd0, 4'd0, 32'd2);
        push_exp(4'd1, 32'd101);
        broadcast(4'd6, 32'd100);
        drain("order_first");
        dispatch(4'(OP_ADD), 4'd3, 4'd7, 32'd0, 4'd0, 32'd3);
`ifdef ALU_STATION_AGE_EN
        push_exp(4'd2, 32'd202);
        push_exp(4'd3, 32'd203);
`else
        push_exp(4'd3, 32'd203);
        push_exp(4'd2, 32'd202);
`endif
        broadcast(4'd7, 32'd200);
        drain("order_pair");

        // Full station: extra dispatch ignored, then wake all and drain under backpressure.
        fill_waiting(4'd5);
        check("full_disp_ready", 32'(io.disp_ready), 32'd0);
        check("full_free_count", 32'(io.free_count), 32'd0);
        set_disp(4'(OP_ADD), 4'd15, 4'd0, 32'd1, 4'd0, 32'd1);
        tick();
        io.disp_valid = 1'b0;
        tick();
        check("full_extra_free", 32'(io.free_count), 32'd0);
        check("full_extra_no_issue", 32'(io.out_valid), 32'd0);
        for (int i = 0; i < RS_DEPTH; i++) push_exp(4'(i + 1), 32'(100 + i));
        io.out_ready = 1'b0;
        broadcast(4'd5, 32'd100);
        tick();
        tick();
        check("full_stall_valid", 32'(io.out_valid), 32'd1);
        for (int g = 0; g < 300 && exp_q.size() != 0; g++) begin
            io.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        io.out_ready = 1'b1;
        drain("full_drain");
        check("empty_free_count", 32'(io.free_count), 32'(RS_DEPTH));
        check("empty_disp_ready", 32'(io.disp_ready), 32'd1);
        check("empty_out_valid", 32'(io.out_valid), 32'd0);

        // Flush with a full station and a held result.
        io.out_ready = 1'b0;
        dispatch(4'(OP_ADD), 4'd9, 4'd0, 32'd1, 4'd0, 32'd1);
        fill_waiting(4'd5);
        check("preflush_out_valid", 32'(io.out_valid), 32'd1);
        check("preflush_free", 32'(io.free_count), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_out_valid", 32'(io.out_valid), 32'd0);
        check("flush_free_count", 32'(io.free_count), 32'(RS_DEPTH));
        check("flush_disp_ready", 32'(io.disp_ready), 32'd1);
        io.out_ready = 1'b1;
        broadcast(4'd5, 32'd77);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_emit", 32'(io.out_valid), 32'd0);
        end

        // Reset together with flush, full station and a held result.
        io.out_ready = 1'b0;
        dispatch(4'(OP_ADD), 4'd9, 4'd0, 32'd3, 4'd0, 32'd4);
        fill_waiting(4'd5);
        check("prerst_out_valid", 32'(io.out_valid), 32'd1);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        check("rst2_out_valid",  32'(io.out_valid),  32'd0);
        check("rst2_out_tag",    32'(io.out_tag),    32'd0);
        check("rst2_out_data",   io.out_data,        32'd0);
        check("rst2_free_count", 32'(io.free_count), 32'(RS_DEPTH));
        check("rst2_disp_ready", 32'(io.disp_ready), 32'd1);
        io.out_ready = 1'b1;
        broadcast(4'd5, 32'd55);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_emit", 32'(io.out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
